// File: rtl/traffic_pkg.sv
// Shared phase codes, light encodings and small helpers
// for the intersection phase scheduler.
package traffic_pkg;

  typedef enum logic [2:0] {
    FLASH    = 3'd0,
    A_GREEN  = 3'd1,
    A_YELLOW = 3'd2,
    CLR_1    = 3'd3,
    B_GREEN  = 3'd4,
    B_YELLOW = 3'd5,
    CLR_2    = 3'd6
  } phase_e;

  localparam logic [2:0] LT_GREEN  = 3'b100;
  localparam logic [2:0] LT_YELLOW = 3'b010;
  localparam logic [2:0] LT_RED    = 3'b001;
  localparam logic [2:0] LT_OFF    = 3'b000;

  function automatic phase_e next_phase(phase_e p);
    phase_e n;
    unique case (p)
      A_GREEN:  n = A_YELLOW;
      A_YELLOW: n = CLR_1;
      CLR_1:    n = B_GREEN;
      B_GREEN:  n = B_YELLOW;
      B_YELLOW: n = CLR_2;
      default:  n = A_GREEN;
    endcase
    return n;
  endfunction

  function automatic logic is_green(phase_e p);
    return (p == A_GREEN) || (p == B_GREEN);
  endfunction

  function automatic logic is_clr(phase_e p);
    return (p == CLR_1) || (p == CLR_2);
  endfunction

  function automatic logic [6:0] clamp7(
    logic [6:0] v,
    logic [6:0] mx
  );
    logic [6:0] r;
    if (v == 7'd0)   r = 7'd1;
    else if (v > mx) r = mx;
    else             r = v;
    return r;
  endfunction

endpackage

// File: rtl/phase_duration_sel.sv
// Clamped durations of the current phase and of the phase
// that follows it; purely combinational.
module phase_duration_sel
  import traffic_pkg::*;
#(
  parameter int MAX_GREEN  = 99,
  parameter int MAX_YELLOW = 4,
  parameter int T_ALLRED   = 1,
  parameter int T_WALK     = 6
) (
  input  phase_e     phase_i,
  input  logic [6:0] t_green_i,
  input  logic [6:0] t_yellow_i,
  input  logic       ped_pending_i,
  input  logic       ped_walk_i,
  output logic [6:0] cur_dur_o,
  output logic [6:0] nxt_dur_o
);

  function automatic logic [6:0] dur(phase_e p, logic walk);
    logic [6:0] d;
    unique case (p)
      A_GREEN, B_GREEN:
        d = clamp7(t_green_i, 7'(MAX_GREEN));
      A_YELLOW, B_YELLOW:
        d = clamp7(t_yellow_i, 7'(MAX_YELLOW));
      CLR_1, CLR_2:
        d = walk ? 7'(T_WALK) : 7'(T_ALLRED);
      default:
        d = 7'd0;
    endcase
    return d;
  endfunction

  // A running clearance keeps its walk length even after
  // the request that caused it has been cleared.
  always_comb begin
    cur_dur_o = dur(phase_i, ped_walk_i);
    nxt_dur_o = dur(next_phase(phase_i), ped_pending_i);
  end

endmodule

// File: rtl/intersection_phase_scheduler.sv
// Two-road phase controller: green/yellow/all-red sequencing,
// display countdown and pedestrian walk handling.
module intersection_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int MAX_GREEN  = 99,
  parameter int MAX_YELLOW = 4,
  parameter int T_ALLRED   = 1,
  parameter int T_WALK     = 6,
  parameter int PED_CUT    = 5
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       tick,
  input  logic       start,
  input  logic       step,
  input  logic       load,
  input  logic [6:0] t_green,
  input  logic [6:0] t_yellow,
  input  logic       ped_req,
  output logic [2:0] phase,
  output logic [2:0] light_a,
  output logic [2:0] light_b,
  output logic [6:0] count,
  output logic       count_valid,
  output logic       ped_walk,
  output logic       ped_pending
);

  phase_e     phase_q, phase_d;
  logic [6:0] count_q, count_d;
  logic       blink_q, blink_d;
  logic       pend_q, pend_d;
  logic       walk_q, walk_d;
  logic [2:0] la_q, lb_q;
  logic [5:0] lights_d;
  logic       cv_q;
  logic [6:0] cur_dur, nxt_dur, lim;
  logic       adv;

  phase_duration_sel #(
    .MAX_GREEN (MAX_GREEN),
    .MAX_YELLOW(MAX_YELLOW),
    .T_ALLRED  (T_ALLRED),
    .T_WALK    (T_WALK)
  ) u_dur (
    .phase_i      (phase_q),
    .t_green_i    (t_green),
    .t_yellow_i   (t_yellow),
    .ped_pending_i(pend_q),
    .ped_walk_i   (walk_q),
    .cur_dur_o    (cur_dur),
    .nxt_dur_o    (nxt_dur)
  );

  function automatic logic [5:0] lights(phase_e p, logic b);
    logic [5:0] l;
    unique case (p)
      A_GREEN:      l = {LT_GREEN, LT_RED};
      A_YELLOW:     l = {LT_YELLOW, LT_RED};
      B_GREEN:      l = {LT_RED, LT_GREEN};
      B_YELLOW:     l = {LT_RED, LT_YELLOW};
      CLR_1, CLR_2: l = {LT_RED, LT_RED};
      default:
        l = b ? {LT_YELLOW, LT_YELLOW} : {LT_OFF, LT_OFF};
    endcase
    return l;
  endfunction

  // Next-state: phase advance, countdown, pedestrian latch.
  always_comb begin
    phase_d = phase_q;
    count_d = count_q;
    pend_d  = pend_q;
    walk_d  = walk_q;
    blink_d = tick ? ~blink_q : blink_q;
    adv     = 1'b0;
    lim     = cur_dur;
    if (is_green(phase_q) && pend_q && lim > 7'(PED_CUT))
      lim = 7'(PED_CUT);
    if (phase_q == FLASH) begin
      adv = start ? tick : step;
    end else if (!start) begin
      adv = step;
    end else if (load) begin
      count_d = cur_dur;
    end else if (tick) begin
      if (count_q <= 7'd1)   adv = 1'b1;
      else if (count_q > lim) count_d = lim;
      else                    count_d = count_q - 7'd1;
    end
    if (adv) begin
      phase_d = next_phase(phase_q);
      count_d = nxt_dur;
      walk_d  = is_clr(phase_d) && pend_q;
      if (walk_d) pend_d = 1'b0;
    end
    if (ped_req) pend_d = 1'b1;
    lights_d = lights(phase_d, blink_d);
  end

  // State and registered outputs.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      phase_q <= FLASH;
      count_q <= 7'd0;
      blink_q <= 1'b1;
      pend_q  <= 1'b0;
      walk_q  <= 1'b0;
      la_q    <= LT_YELLOW;
      lb_q    <= LT_YELLOW;
      cv_q    <= 1'b0;
    end else begin
      phase_q <= phase_d;
      count_q <= count_d;
      blink_q <= blink_d;
      pend_q  <= pend_d;
      walk_q  <= walk_d;
      la_q    <= lights_d[5:3];
      lb_q    <= lights_d[2:0];
      cv_q    <= start && (phase_d != FLASH);
    end
  end

  assign phase       = phase_q;
  assign count       = count_q;
  assign light_a     = la_q;
  assign light_b     = lb_q;
  assign count_valid = cv_q;
  assign ped_walk    = walk_q;
  assign ped_pending = pend_q;

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Directed bench for intersection_phase_scheduler:
// sequencing, clamps, pedestrian, manual, load and reset.
module tb_intersection_phase_scheduler;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       start = 1'b0;
  logic       step = 1'b0;
  logic       load = 1'b0;
  logic [6:0] t_green = 7'd3;
  logic [6:0] t_yellow = 7'd2;
  logic       ped_req = 1'b0;
  logic [2:0] phase;
  logic [2:0] light_a;
  logic [2:0] light_b;
  logic [6:0] count;
  logic       count_valid;
  logic       ped_walk;
  logic       ped_pending;

  int checks = 0;
  int failures = 0;

  intersection_phase_scheduler dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .tick       (tick),
    .start      (start),
    .step       (step),
    .load       (load),
    .t_green    (t_green),
    .t_yellow   (t_yellow),
    .ped_req    (ped_req),
    .phase      (phase),
    .light_a    (light_a),
    .light_b    (light_b),
    .count      (count),
    .count_valid(count_valid),
    .ped_walk   (ped_walk),
    .ped_pending(ped_pending)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic do_tick(int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      @(negedge CLOCK_50);
      tick = 1'b0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    reset = 1'b0;
    @(negedge CLOCK_50);
  endtask

  task automatic test_reset();
    logic [18:0] obs;
    reset = 1'b1;
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    obs = {phase, count, light_a, light_b,
           count_valid, ped_walk, ped_pending};
    checks++;
    if (obs !== {3'd0, 7'd0, 3'b010, 3'b010, 3'b000}) begin
      failures++;
      $display("FAIL reset_state got=%h exp=%h", obs,
               {3'd0, 7'd0, 3'b010, 3'b010, 3'b000});
    end
    reset = 1'b0;
    @(negedge CLOCK_50);
  endtask

  task automatic test_sequence();
    logic [15:0] exp [1:7];
    logic [15:0] obs;
    exp[1] = {3'd1, 7'd3, 3'b100, 3'b001};
    exp[2] = {3'd1, 7'd2, 3'b100, 3'b001};
    exp[3] = {3'd1, 7'd1, 3'b100, 3'b001};
    exp[4] = {3'd2, 7'd2, 3'b010, 3'b001};
    exp[5] = {3'd2, 7'd1, 3'b010, 3'b001};
    exp[6] = {3'd3, 7'd1, 3'b001, 3'b001};
    exp[7] = {3'd4, 7'd3, 3'b001, 3'b100};
    t_green = 7'd3;
    t_yellow = 7'd2;
    start = 1'b1;
    @(negedge CLOCK_50);
    checks++;
    if (phase !== 3'd0 || count_valid !== 1'b0) begin
      failures++;
      $display("FAIL flash_hold got=%0d/%0b exp=0/0",
               phase, count_valid);
    end
    for (int k = 1; k <= 7; k++) begin
      do_tick(1);
      obs = {phase, count, light_a, light_b};
      checks++;
      if (obs !== exp[k]) begin
        failures++;
        $display("FAIL seq_tick%0d got=%h exp=%h", k, obs, exp[k]);
      end
    end
    checks++;
    if (count_valid !== 1'b1) begin
      failures++;
      $display("FAIL seq_valid got=%0b exp=1", count_valid);
    end
  endtask

  task automatic test_step_ignored();
    step = 1'b1;
    @(negedge CLOCK_50);
    step = 1'b0;
    @(negedge CLOCK_50);
    checks++;
    if ({phase, count} !== {3'd4, 7'd3}) begin
      failures++;
      $display("FAIL step_running got=%0d/%0d exp=4/3",
               phase, count);
    end
  endtask

  task automatic test_clamp();
    t_green = 7'd0;
    t_yellow = 7'd9;
    do_reset();
    do_tick(1);
    checks++;
    if ({phase, count} !== {3'd1, 7'd1}) begin
      failures++;
      $display("FAIL clamp_green got=%0d/%0d exp=1/1",
               phase, count);
    end
    do_tick(1);
    checks++;
    if ({phase, count} !== {3'd2, 7'd4}) begin
      failures++;
      $display("FAIL clamp_yellow got=%0d/%0d exp=2/4",
               phase, count);
    end
    do_tick(3);
    checks++;
    if ({phase, count} !== {3'd2, 7'd1}) begin
      failures++;
      $display("FAIL clamp_ylast got=%0d/%0d exp=2/1",
               phase, count);
    end
    do_tick(1);
    checks++;
    if ({phase, count} !== {3'd3, 7'd1}) begin
      failures++;
      $display("FAIL clamp_clr got=%0d/%0d exp=3/1",
               phase, count);
    end
  endtask

  task automatic test_ped();
    t_green = 7'd20;
    t_yellow = 7'd2;
    do_reset();
    do_tick(6);
    checks++;
    if ({phase, count} !== {3'd1, 7'd15}) begin
      failures++;
      $display("FAIL ped_pre got=%0d/%0d exp=1/15",
               phase, count);
    end
    ped_req = 1'b1;
    @(negedge CLOCK_50);
    ped_req = 1'b0;
    checks++;
    if (ped_pending !== 1'b1 || count !== 7'd15) begin
      failures++;
      $display("FAIL ped_latch got=%0b/%0d exp=1/15",
               ped_pending, count);
    end
    do_tick(1);
    checks++;
    if (count !== 7'd5) begin
      failures++;
      $display("FAIL ped_cut got=%0d exp=5", count);
    end
    do_tick(7);
    checks++;
    if ({phase, count, ped_walk, ped_pending}
        !== {3'd3, 7'd6, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL ped_clr got=%0d/%0d/%0b/%0b exp=3/6/1/0",
               phase, count, ped_walk, ped_pending);
    end
    do_tick(5);
    checks++;
    if ({phase, count, ped_walk} !== {3'd3, 7'd1, 1'b1}) begin
      failures++;
      $display("FAIL ped_walk_end got=%0d/%0d/%0b exp=3/1/1",
               phase, count, ped_walk);
    end
    do_tick(1);
    checks++;
    if ({phase, count, ped_walk, ped_pending}
        !== {3'd4, 7'd20, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL ped_after got=%0d/%0d/%0b/%0b exp=4/20/0/0",
               phase, count, ped_walk, ped_pending);
    end
  endtask

  task automatic test_manual();
    t_green = 7'd3;
    do_tick(1);
    checks++;
    if (count !== 7'd3) begin
      failures++;
      $display("FAIL live_clamp got=%0d exp=3", count);
    end
    do_tick(3);
    checks++;
    if ({phase, count} !== {3'd5, 7'd2}) begin
      failures++;
      $display("FAIL man_byellow got=%0d/%0d exp=5/2",
               phase, count);
    end
    start = 1'b0;
    do_tick(10);
    checks++;
    if ({phase, count, count_valid} !== {3'd5, 7'd2, 1'b0}) begin
      failures++;
      $display("FAIL man_frozen got=%0d/%0d/%0b exp=5/2/0",
               phase, count, count_valid);
    end
    step = 1'b1;
    @(negedge CLOCK_50);
    step = 1'b0;
    checks++;
    if ({phase, count, light_a, light_b, count_valid}
        !== {3'd6, 7'd1, 3'b001, 3'b001, 1'b0}) begin
      failures++;
      $display("FAIL man_step got=%0d/%0d/%b/%b/%0b exp=6/1/001/001/0",
               phase, count, light_a, light_b, count_valid);
    end
  endtask

  task automatic test_load();
    t_green = 7'd7;
    start = 1'b1;
    do_reset();
    do_tick(1);
    checks++;
    if ({phase, count} !== {3'd1, 7'd7}) begin
      failures++;
      $display("FAIL load_pre got=%0d/%0d exp=1/7", phase, count);
    end
    t_green = 7'd12;
    load = 1'b1;
    @(negedge CLOCK_50);
    checks++;
    if (count !== 7'd12) begin
      failures++;
      $display("FAIL load_set got=%0d exp=12", count);
    end
    do_tick(1);
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    checks++;
    if ({phase, count} !== {3'd1, 7'd12}) begin
      failures++;
      $display("FAIL load_hold got=%0d/%0d exp=1/12",
               phase, count);
    end
    load = 1'b0;
    do_tick(1);
    checks++;
    if (count !== 7'd11) begin
      failures++;
      $display("FAIL load_release got=%0d exp=11", count);
    end
  endtask

  task automatic test_reset_mid();
    logic [17:0] obs;
    ped_req = 1'b1;
    @(negedge CLOCK_50);
    ped_req = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    obs = {phase, count, light_a, light_b, count_valid, ped_pending};
    checks++;
    if (obs !== {3'd0, 7'd0, 3'b010, 3'b010, 2'b00}) begin
      failures++;
      $display("FAIL reset_mid got=%h exp=%h", obs,
               {3'd0, 7'd0, 3'b010, 3'b010, 2'b00});
    end
    @(negedge CLOCK_50);
    reset = 1'b0;
    @(negedge CLOCK_50);
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_step_ignored();
    test_clamp();
    test_ped();
    test_manual();
    test_load();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
